// File: rtl/three_d_ecc_scrub_ctrl.sv
// 3D-parity (4 layers x 2 bits) protected codeword store with host port and background scrub.
// Optional correction/writeback path enabled by defining THREE_D_ECC_CORRECT_EN.
module three_d_ecc_scrub_ctrl #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_corrected,
  input  logic                  scrub_en,
  output logic                  scrub_uncorr,
  input  logic                  inj_valid,
  input  logic [ADDR_WIDTH-1:0] inj_addr,
  input  logic [15:0]           inj_mask,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr
);

  localparam int unsigned SC_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, WB} state_t;

  // Parity field {overall, bit[1:0], layer[3:0]} occupying codeword bits [14:8].
  function automatic logic [6:0] par(input logic [7:0] d);
    logic [6:0] p;
    p = '0;
    for (int unsigned k = 0; k < 4; k++) p[k] = d[2*k] ^ d[2*k+1];
    for (int unsigned j = 0; j < 2; j++) p[4+j] = d[j] ^ d[2+j] ^ d[4+j] ^ d[6+j];
    p[6] = ^d;
    return p;
  endfunction

  state_t                  state_q, state_d;
  logic [15:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              wdata_q;
  logic [14:0]             cw_q;
  logic                    is_scrub;
  logic [ADDR_WIDTH-1:0]   scrub_addr;
  logic [SC_W-1:0]         scrub_cnt;
  logic                    scrub_pending;
  logic                    host_go;
  logic                    mem_we;

  logic [6:0]              syn;
  logic                    chk_nonzero;
  logic [7:0]              chk_data;
  logic                    chk_err;
  logic                    chk_corr;
`ifdef THREE_D_ECC_CORRECT_EN
  logic [7:0]              flip;
  logic                    single_data;
  logic                    single_par;
`endif

  assign req_ready = !rst && (state_q == IDLE) && !scrub_pending;
  assign host_go   = req_valid && req_ready;
  assign mem_we    = (state_q == WR) || (state_q == WB);

  always_comb begin
    syn         = cw_q[14:8] ^ par(cw_q[7:0]);
    chk_nonzero = |syn;
    chk_data    = cw_q[7:0];
    chk_corr    = 1'b0;
    chk_err     = chk_nonzero;
`ifdef THREE_D_ECC_CORRECT_EN
    // A lone layer bit and lone bit-position bit with overall set pinpoint data bit 2k+j.
    flip = '0;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned j = 0; j < 2; j++)
        flip[2*k+j] = syn[k] & syn[4+j];
    single_data = syn[6] && $onehot(syn[5:4]) && $onehot(syn[3:0]);
    single_par  = $onehot(syn);
    if (single_data) chk_data = cw_q[7:0] ^ flip;
    chk_corr = single_data || single_par;
    chk_err  = chk_nonzero && !chk_corr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scrub_pending)  state_d = RD;
        else if (req_valid) state_d = req_write ? WR : RD;
      end
      RD:      state_d = CHK;
      CHK:     state_d = chk_corr ? WB : IDLE;
      WR, WB:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      cw_q          <= '0;
      is_scrub      <= 1'b0;
      scrub_addr    <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_corrected <= 1'b0;
      scrub_uncorr  <= 1'b0;
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      rsp_valid    <= 1'b0;
      scrub_uncorr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scrub_pending) begin
            addr_q   <= scrub_addr;
            is_scrub <= 1'b1;
          end else if (host_go) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            is_scrub <= 1'b0;
          end
        end
        RD: cw_q <= mem[addr_q][14:0];
        CHK: begin
          wdata_q <= chk_data;
          if (chk_nonzero) begin
            if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
            last_err_addr <= addr_q;
          end
          if (is_scrub) begin
            scrub_uncorr <= chk_err;
            scrub_addr   <= (scrub_addr == ADDR_LAST) ? '0 : scrub_addr + ADDR_WIDTH'(1);
          end else begin
            rsp_valid     <= 1'b1;
            rsp_rdata     <= chk_data;
            rsp_err       <= chk_err;
            rsp_corrected <= chk_corr;
          end
        end
        default: ;
      endcase
    end
  end

  // An expiry while a scrub is still pending simply re-sets the flag, so it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      scrub_cnt     <= '0;
      scrub_pending <= 1'b0;
    end else begin
      if (state_q == IDLE && scrub_pending) scrub_pending <= 1'b0;
      if (scrub_en) begin
        if (scrub_cnt == SC_LAST) begin
          scrub_cnt     <= '0;
          scrub_pending <= 1'b1;
        end else begin
          scrub_cnt <= scrub_cnt + SC_W'(1);
        end
      end
    end
  end

  // Write/writeback to the same entry takes precedence over a concurrent injection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_we && addr_q == ADDR_WIDTH'(i))
          mem[i] <= {1'b0, par(wdata_q), wdata_q};
        else if (inj_valid && inj_addr == ADDR_WIDTH'(i))
          mem[i] <= mem[i] ^ inj_mask;
      end
    end
  end

endmodule

// File: tb/tb_three_d_ecc_scrub_ctrl.sv
// Scoreboard bench for three_d_ecc_scrub_ctrl; honours THREE_D_ECC_CORRECT_EN like the design.
module tb_three_d_ecc_scrub_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid, rsp_err, rsp_corrected, scrub_uncorr;
  logic [7:0]  rsp_rdata;
  logic        scrub_en = 1'b0;
  logic        inj_valid = 1'b0;
  logic [3:0]  inj_addr = '0;
  logic [15:0] inj_mask = '0;
  logic [7:0]  err_count;
  logic [3:0]  last_err_addr;

  always #5 clk = ~clk;

  three_d_ecc_scrub_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .SCRUB_INTERVAL(64), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_corrected(rsp_corrected), .scrub_en(scrub_en),
    .scrub_uncorr(scrub_uncorr), .inj_valid(inj_valid), .inj_addr(inj_addr), .inj_mask(inj_mask),
    .err_count(err_count), .last_err_addr(last_err_addr)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       corr;
    logic [7:0] cnt;
    logic [3:0] last;
    int         acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl_mem [DEPTH];
  int          mdl_cnt = 0;
  logic [3:0]  mdl_last = '0;
  int          uncorr_seen = 0;
  int          checks = 0, fails = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference encoder built directly from the parity equations with integer arithmetic.
  function automatic logic [15:0] m_enc(input logic [7:0] d);
    int r, ones;
    r = int'(d);
    for (int k = 0; k < 4; k++)
      if (((d >> (2*k)) & 1) != ((d >> (2*k+1)) & 1)) r += (1 << (8+k));
    for (int j = 0; j < 2; j++) begin
      ones = 0;
      for (int m = 0; m < 4; m++) ones += int'((d >> (2*m+j)) & 1);
      if (ones % 2 == 1) r += (1 << (12+j));
    end
    if ($countones(d) % 2 == 1) r += (1 << 14);
    return 16'(r);
  endfunction

  task automatic model_read(input int a, output exp_t e);
    logic [15:0] cw, ref_cw;
    logic [6:0]  s;
    cw     = mdl_mem[a];
    ref_cw = m_enc(cw[7:0]);
    s      = cw[14:8] ^ ref_cw[14:8];
    e.rdata = cw[7:0];
    e.err   = 1'b0;
    e.corr  = 1'b0;
    e.acc   = 0;
    if (s != 0) begin
      if (mdl_cnt < 255) mdl_cnt++;
      mdl_last = 4'(a);
`ifdef THREE_D_ECC_CORRECT_EN
      begin
        int kk, jj;
        kk = 0; jj = 0;
        for (int k = 0; k < 4; k++) if (s[k]) kk = k;
        for (int j = 0; j < 2; j++) if (s[4+j]) jj = j;
        if (s[6] && $countones(s[3:0]) == 1 && $countones(s[5:4]) == 1) begin
          e.rdata = cw[7:0] ^ 8'(1 << (2*kk + jj));
          e.corr  = 1'b1;
          mdl_mem[a] = m_enc(e.rdata);
        end else if ($countones(s) == 1) begin
          e.corr = 1'b1;
          mdl_mem[a] = m_enc(cw[7:0]);
        end else begin
          e.err = 1'b1;
        end
      end
`else
      e.err = 1'b1;
`endif
    end
    e.cnt  = 8'(mdl_cnt);
    e.last = mdl_last;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (scrub_uncorr) uncorr_seen++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no read outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_corrected", rsp_corrected, e.corr);
        check("err_count", err_count, e.cnt);
        check("last_err_addr", last_err_addr, e.last);
        check("rsp_latency", cyc, e.acc + 2);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    mdl_cnt  = 0;
    mdl_last = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", req_ready, 1);
  endtask

  // Returns on the negedge after the accepting edge.
  task automatic host_req(input bit wr, input int a, input logic [7:0] d, input bit track);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = 4'(a); req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("handshake_timeout", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (track) begin
      if (wr) mdl_mem[a] = m_enc(d);
      else begin
        model_read(a, e);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic inject(input int a, input logic [15:0] m);
    @(negedge clk);
    inj_valid = 1'b1; inj_addr = 4'(a); inj_mask = m;
    @(negedge clk);
    inj_valid = 1'b0;
    mdl_mem[a] = mdl_mem[a] ^ m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_in_reset", req_ready, 0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin
    int   r, a, low, n;
    logic [15:0] m;
    model_clear();
    repeat (3) @(negedge clk);
    check("ready_in_reset", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_err_count", err_count, 0);
    check("reset_last_err", last_err_addr, 0);
    check("reset_scrub_uncorr", scrub_uncorr, 0);

    host_req(1, 3, 8'hA5, 1); wait_idle();
    check("cw_a5", dut.mem[3], 16'h0FA5);
    host_req(0, 3, 8'h00, 1); wait_idle();
    inject(3, 16'h0004);
    host_req(0, 3, 8'h00, 1); wait_idle();
`ifdef THREE_D_ECC_CORRECT_EN
    check("cw_after_fix", dut.mem[3], 16'h0FA5);
`else
    check("cw_after_fix", dut.mem[3], 16'h0FA1);
`endif
    host_req(1, 3, 8'hA5, 1); wait_idle();
    inject(3, 16'h0003);
    host_req(0, 3, 8'h00, 1); wait_idle();

    host_req(1, 7, 8'h3C, 1);
    inj_valid = 1'b1; inj_addr = 4'd7; inj_mask = 16'hFFFF;
    @(negedge clk);
    inj_valid = 1'b0;
    check("write_beats_inject", dut.mem[7], m_enc(8'h3C));
    wait_idle();
    host_req(1, 8, 8'h11, 1);
    inj_valid = 1'b1; inj_addr = 4'd9; inj_mask = 16'h0100;
    @(negedge clk);
    inj_valid = 1'b0;
    mdl_mem[9] = mdl_mem[9] ^ 16'h0100;
    wait_idle();
    host_req(0, 9, 8'h00, 1); wait_idle();
    host_req(0, 7, 8'h00, 1); wait_idle();

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, DEPTH - 1);
      if (r < 3) begin
        host_req(1, a, 8'($urandom), 1); wait_idle();
      end else if (r < 7) begin
        host_req(0, a, 8'h00, 1); wait_idle();
      end else begin
        case ($urandom_range(0, 2))
          0:       m = 16'(1 << $urandom_range(0, 15));
          1:       m = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
          default: m = 16'($urandom);
        endcase
        inject(a, m);
      end
    end

    scrub_en = 1'b1;
    do_reset();
    uncorr_seen = 0;
    inject(0, 16'h0010);
    repeat (75) @(negedge clk);
    scrub_en = 1'b0;
    check("scrub_err_count", err_count, 1);
    check("scrub_last_err", last_err_addr, 0);
    check("scrub_addr_step", dut.scrub_addr, 1);
`ifdef THREE_D_ECC_CORRECT_EN
    check("scrub_uncorr_pulses", uncorr_seen, 0);
    check("scrub_writeback", dut.mem[0], 16'h0000);
    mdl_mem[0] = 16'h0000;
`else
    check("scrub_uncorr_pulses", uncorr_seen, 1);
    check("scrub_no_writeback", dut.mem[0], 16'h0010);
`endif
    mdl_cnt = 1;
    mdl_last = 4'd0;
    host_req(0, 0, 8'h00, 1); wait_idle();

    scrub_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dut.scrub_pending && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scrub_pending_seen", dut.scrub_pending, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    check("ready_blocked_by_scrub", req_ready, 0);
    low = 1;
    while (!req_ready && low < 20) begin
      @(negedge clk);
      if (!req_ready) low++;
    end
    check("scrub_first_cycles", low, 3);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    scrub_en = 1'b0;
    begin
      exp_t e;
      model_read(5, e);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    wait_idle();
    check("scrub_addr_after", dut.scrub_addr, 2);

    host_req(1, 2, 8'h5A, 1); wait_idle();
    host_req(1, 9, 8'hFF, 1); wait_idle();
    host_req(0, 2, 8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rdata", rsp_rdata, 0);
    check("abort_err", rsp_err, 0);
    check("abort_corr", rsp_corrected, 0);
    check("abort_scrub_uncorr", scrub_uncorr, 0);
    check("abort_err_count", err_count, 0);
    check("abort_last_err", last_err_addr, 0);
    check("abort_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      host_req(0, i, 8'h00, 1); wait_idle();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
